// File: rtl/spu_sm_pkg.sv
// Softmax sequencer shared definitions: phase codes and default latencies,
// also imported by the softmax datapath.
package spu_sm_pkg;

  typedef enum logic [2:0] {
    SM_IDLE       = 3'b000,
    SM_EU_STAGE_A = 3'b001,
    SM_RECI       = 3'b011,
    SM_EU_STAGE_B = 3'b100,
    SM_MAX        = 3'b101
  } sm_state_e;

  localparam int SM_AW_DEF      = 10;
  localparam int SM_RD_LAT_DEF  = 1;
  localparam int SM_EUA_LAT_DEF = 1;
  localparam int SM_EUB_LAT_DEF = 2;
  localparam int SM_PERF_W      = 24;

  function automatic int sm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spu_sm_ctrl_if.sv
// Row-buffer port and softmax datapath strobes driven by the sequencer.
interface spu_sm_ctrl_if #(
  parameter int AW = 10
);
  logic [2:0]    sm_state;
  logic          comp_rst;
  logic          comp_en;
  logic          adder_tree_en;
  logic          reci_exp_sum_en;
  logic          reci_exp_sum_finish;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;

  modport master (
    output sm_state, comp_rst, comp_en, adder_tree_en, reci_exp_sum_en,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
    input  reci_exp_sum_finish
  );

  modport slave (
    input  sm_state, comp_rst, comp_en, adder_tree_en, reci_exp_sum_en,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
    output reci_exp_sum_finish
  );
endinterface

// File: rtl/spu_sm_vld_pipe.sv
// Valid+address delay line with a selectable output tap (1..DEPTH) and a
// flag telling whether anything is still in flight ahead of that tap.
module spu_sm_vld_pipe #(
  parameter int AW    = 10,
  parameter int DEPTH = 1,
  parameter int TW    = $clog2(DEPTH + 1)
) (
  input  logic          core_clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  input  logic [TW-1:0] tap,
  output logic          out_vld,
  output logic [AW-1:0] out_addr,
  output logic          pend
);

  logic [DEPTH-1:0] vld_p;
  logic [AW-1:0]    addr_p [DEPTH];

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
    end else if (clr) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
    end else begin
      vld_p[0]  <= in_vld;
      addr_p[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  always_comb begin
    out_vld  = 1'b0;
    out_addr = '0;
    pend     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == int'(tap) - 1) begin
        out_vld  = vld_p[i];
        out_addr = addr_p[i];
      end else if (i < int'(tap) - 1) begin
        pend = pend | vld_p[i];
      end
    end
  end

endmodule

// File: rtl/spu_sm_ctrl.sv
// Softmax row sequencer: MAX -> EU_STAGE_A -> RECI -> EU_STAGE_B over one row.
// Optional per-row cycle counter enabled by SPU_SM_CTRL_PERF_EN.
module spu_sm_ctrl
  import spu_sm_pkg::*;
#(
  parameter int AW      = SM_AW_DEF,
  parameter int RD_LAT  = SM_RD_LAT_DEF,
  parameter int EUA_LAT = SM_EUA_LAT_DEF,
  parameter int EUB_LAT = SM_EUB_LAT_DEF
) (
  input  logic                 core_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        row_len,
  output logic                 busy,
  output logic                 done,
  output logic [SM_PERF_W-1:0] perf_cycles,
  spu_sm_ctrl_if.master        dp
);

  localparam int WA_LAT   = RD_LAT + EUA_LAT;
  localparam int WB_LAT   = RD_LAT + EUB_LAT;
  localparam int WR_DEPTH = sm_max(WA_LAT, WB_LAT);
  localparam int RTW      = $clog2(RD_LAT + 1);
  localparam int WTW      = $clog2(WR_DEPTH + 1);

  sm_state_e     state_q, state_d;
  logic [AW-1:0] base_q, len_q, rd_cnt_q, rd_addr;
  logic          reci_sent_q, done_q;
  logic          rd_en, rd_done, wr_en, comp_rst, comp_en, adder_en, reci_en, row_done;
  logic          rd_vld, rd_pend, wr_vld, wr_pend, pipe_clr, accept_row;
  logic [AW-1:0] wr_addr, rd_addr_unused;
  logic [WTW-1:0] wr_tap;

  assign rd_done    = (rd_cnt_q == len_q);
  assign rd_addr    = base_q + rd_cnt_q;
  assign pipe_clr   = (state_d != state_q);
  assign accept_row = (state_q == SM_IDLE) && start && (row_len != '0);
  assign wr_tap     = (state_q == SM_EU_STAGE_A) ? WTW'(WA_LAT) : WTW'(WB_LAT);

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    comp_rst = 1'b0;
    comp_en  = 1'b0;
    adder_en = 1'b0;
    reci_en  = 1'b0;
    row_done = 1'b0;
    case (state_q)
      SM_IDLE: if (accept_row) state_d = SM_MAX;
      SM_MAX: begin
        rd_en    = !rd_done;
        comp_rst = (rd_cnt_q == '0);
        comp_en  = rd_vld;
        if (rd_done && rd_vld && !rd_pend) state_d = SM_EU_STAGE_A;
      end
      SM_EU_STAGE_A: begin
        rd_en    = !rd_done;
        wr_en    = wr_vld;
        adder_en = wr_vld;
        if (rd_done && wr_vld && !wr_pend) state_d = SM_RECI;
      end
      // finish in the same cycle as the en pulse advances immediately
      SM_RECI: begin
        reci_en = !reci_sent_q;
        if (dp.reci_exp_sum_finish) state_d = SM_EU_STAGE_B;
      end
      SM_EU_STAGE_B: begin
        rd_en = !rd_done;
        wr_en = wr_vld;
        if (rd_done && wr_vld && !wr_pend) begin
          state_d  = SM_IDLE;
          row_done = 1'b1;
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SM_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      reci_sent_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_row) begin
        base_q <= base_addr;
        len_q  <= row_len;
      end
      rd_cnt_q    <= pipe_clr ? '0 : rd_cnt_q + AW'(rd_en);
      reci_sent_q <= (state_q == SM_RECI);
      done_q      <= ((state_q == SM_IDLE) && start && (row_len == '0)) || row_done;
    end
  end

  // stage p0..: read-side strobe for the MAX comparator
  spu_sm_vld_pipe #(.AW(AW), .DEPTH(RD_LAT), .TW(RTW)) u_rd_pipe (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .clr      (pipe_clr),
    .in_vld   (rd_en),
    .in_addr  (rd_addr),
    .tap      (RTW'(RD_LAT)),
    .out_vld  (rd_vld),
    .out_addr (rd_addr_unused),
    .pend     (rd_pend)
  );

  // stage p0..: write-back strobe, tapped per EU phase
  spu_sm_vld_pipe #(.AW(AW), .DEPTH(WR_DEPTH), .TW(WTW)) u_wr_pipe (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .clr      (pipe_clr),
    .in_vld   (rd_en && (state_q != SM_MAX)),
    .in_addr  (rd_addr),
    .tap      (wr_tap),
    .out_vld  (wr_vld),
    .out_addr (wr_addr),
    .pend     (wr_pend)
  );

  assign busy                = (state_q != SM_IDLE);
  assign done                = done_q;
  assign dp.sm_state         = state_q;
  assign dp.comp_rst         = comp_rst;
  assign dp.comp_en          = comp_en;
  assign dp.adder_tree_en    = adder_en;
  assign dp.reci_exp_sum_en  = reci_en;
  assign dp.mem_rd_en        = rd_en;
  assign dp.mem_rd_addr      = rd_en ? rd_addr : '0;
  assign dp.mem_wr_en        = wr_en;
  assign dp.mem_wr_addr      = wr_en ? wr_addr : '0;

`ifdef SPU_SM_CTRL_PERF_EN
  logic [SM_PERF_W-1:0] perf_q;
  logic                 perf_run_q;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else if ((state_q == SM_IDLE) && start) begin
      perf_q     <= SM_PERF_W'(1);
      perf_run_q <= 1'b1;
    end else if (perf_run_q) begin
      if (perf_q != '1) perf_q <= perf_q + 1'b1;
      if (done_q) perf_run_q <= 1'b0;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_spu_sm_ctrl.sv
// Directed bench for spu_sm_ctrl; perf expectation follows SPU_SM_CTRL_PERF_EN.
module tb_spu_sm_ctrl;

  logic        core_clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  row_len;
  logic        busy;
  logic        done;
  logic [23:0] perf_cycles;

  int checks = 0;
  int errors = 0;

  spu_sm_ctrl_if #(.AW(10)) dp_if ();

  spu_sm_ctrl #(.AW(10), .RD_LAT(1), .EUA_LAT(1), .EUB_LAT(2)) dut (
    .core_clk    (core_clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .row_len     (row_len),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles),
    .dp          (dp_if)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  task automatic chk_zero(input string tag);
    logic [54:0] v;
    v = {busy, done, perf_cycles, dp_if.sm_state, dp_if.comp_rst, dp_if.comp_en,
         dp_if.adder_tree_en, dp_if.reci_exp_sum_en, dp_if.mem_rd_en, dp_if.mem_rd_addr,
         dp_if.mem_wr_en, dp_if.mem_wr_addr};
    chk(tag, 64'(v), 64'd0);
  endtask

  initial begin
    logic [2:0]  exp_state;
    logic [5:0]  exp_strb;
    logic [9:0]  ea;
    logic        exp_rd, exp_wr;
    int          off, exp_perf, bad, traffic, reci_n, dones, done_c, rd_n, wr_n;
    int          wr_a, wr_b, entries, reci_cyc;
    logic        seen_busy;
    logic [2:0]  prev_state;

`ifdef SPU_SM_CTRL_PERF_EN
    exp_perf = 26;
`else
    exp_perf = 0;
`endif

    rst_n = 1'b0; start = 1'b0; base_addr = '0; row_len = '0;
    dp_if.reci_exp_sum_finish = 1'b0;
    tick();
    start = 1'b1; row_len = 10'd4;
    tick();
    chk_zero("reset_all_zero");
    rst_n = 1'b1; start = 1'b0;
    tick();

    // Row of 4 words from 0x3FE, finish 5 cycles after reci_exp_sum_en
    base_addr = 10'h3FE; row_len = 10'd4; start = 1'b1;
    chk("t1_c0_busy", 64'(busy), 64'd0);
    for (int c = 1; c <= 27; c++) begin
      tick();
      start = 1'b0;
      dp_if.reci_exp_sum_finish = (c == 17);
      exp_state = (c <= 5) ? 3'b101 : (c <= 11) ? 3'b001 : (c <= 17) ? 3'b011 :
                  (c <= 24) ? 3'b100 : 3'b000;
      exp_strb = {(c == 1), (c >= 2 && c <= 5), (c >= 8 && c <= 11), (c == 12),
                  (c == 25), (c <= 24)};
      exp_rd = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 18 && c <= 21);
      exp_wr = (c >= 8 && c <= 11) || (c >= 21 && c <= 24);
      chk($sformatf("t1_state_c%0d", c), 64'(dp_if.sm_state), 64'(exp_state));
      chk($sformatf("t1_strb_c%0d", c),
          64'({dp_if.comp_rst, dp_if.comp_en, dp_if.adder_tree_en,
               dp_if.reci_exp_sum_en, done, busy}), 64'(exp_strb));
      chk($sformatf("t1_rden_c%0d", c), 64'(dp_if.mem_rd_en), 64'(exp_rd));
      chk($sformatf("t1_wren_c%0d", c), 64'(dp_if.mem_wr_en), 64'(exp_wr));
      if (exp_rd) begin
        off = (c <= 4) ? c - 1 : (c <= 9) ? c - 6 : c - 18;
        ea = 10'h3FE + 10'(off);
        chk($sformatf("t1_rdaddr_c%0d", c), 64'(dp_if.mem_rd_addr), 64'(ea));
      end
      if (exp_wr) begin
        off = (c <= 11) ? c - 8 : c - 21;
        ea = 10'h3FE + 10'(off);
        chk($sformatf("t1_wraddr_c%0d", c), 64'(dp_if.mem_wr_addr), 64'(ea));
      end
    end
    chk("t1_perf", 64'(perf_cycles), 64'(exp_perf));

    // Zero-length row
    base_addr = 10'd5; row_len = 10'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_done_c1", 64'(done), 64'd1);
    chk("t2_state_c1", 64'(dp_if.sm_state), 64'd0);
    chk("t2_mem_c1", 64'({dp_if.mem_rd_en, dp_if.mem_wr_en}), 64'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dp_if.mem_rd_en || dp_if.mem_wr_en || done || busy) bad++;
    end
    chk("t2_quiet", 64'(bad), 64'd0);
`ifdef SPU_SM_CTRL_PERF_EN
    exp_perf = 2;
`else
    exp_perf = 0;
`endif
    chk("t2_perf", 64'(perf_cycles), 64'(exp_perf));

    // RECI hold with finish low for 100 cycles
    base_addr = 10'h010; row_len = 10'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && dp_if.sm_state != 3'b011; i++) tick();
    chk("t3_reach_reci", 64'(dp_if.sm_state), 64'd3);
    bad = 0; traffic = 0; reci_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (dp_if.sm_state != 3'b011) bad++;
      if (dp_if.mem_rd_en || dp_if.mem_wr_en) traffic++;
      if (dp_if.reci_exp_sum_en) reci_n++;
      tick();
    end
    chk("t3_hold_state", 64'(bad), 64'd0);
    chk("t3_no_traffic", 64'(traffic), 64'd0);
    chk("t3_reci_pulses", 64'(reci_n), 64'd1);
    dp_if.reci_exp_sum_finish = 1'b1;
    tick();
    dp_if.reci_exp_sum_finish = 1'b0;
    chk("t3_enter_eub", 64'(dp_if.sm_state), 64'd4);
    for (int i = 0; i < 30 && !done; i++) tick();
    chk("t3_done", 64'(done), 64'd1);
    tick();

    // start held high through a row; finish tied high (same-cycle ack)
    dp_if.reci_exp_sum_finish = 1'b1;
    base_addr = 10'h100; row_len = 10'd3; start = 1'b1;
    dones = 0; done_c = 0; rd_n = 0; wr_n = 0; entries = 0; reci_cyc = 0;
    seen_busy = 1'b0; prev_state = 3'b000;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (prev_state == 3'b000 && dp_if.sm_state == 3'b101) entries++;
      if (dp_if.sm_state == 3'b011) reci_cyc++;
      if (dp_if.mem_rd_en) rd_n++;
      if (dp_if.mem_wr_en) wr_n++;
      if (done) begin dones++; done_c = c; end
      if (seen_busy && !busy) start = 1'b0;
      if (busy) seen_busy = 1'b1;
      prev_state = dp_if.sm_state;
    end
    start = 1'b0;
    dp_if.reci_exp_sum_finish = 1'b0;
    chk("t4_entries", 64'(entries), 64'd1);
    chk("t4_dones", 64'(dones), 64'd1);
    chk("t4_done_cycle", 64'(done_c), 64'd17);
    chk("t4_reci_cycles", 64'(reci_cyc), 64'd1);
    chk("t4_reads", 64'(rd_n), 64'd9);
    chk("t4_writes", 64'(wr_n), 64'd6);

    // Reset during EU_STAGE_A, then a clean 2-word row across the wrap
    base_addr = 10'h000; row_len = 10'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && dp_if.sm_state != 3'b001; i++) tick();
    chk("t5_reach_eua", 64'(dp_if.sm_state), 64'd1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_zero("t5_reset_async");
    start = 1'b1; row_len = 10'd2;
    tick();
    chk_zero("t5_reset_hold");
    rst_n = 1'b1; start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || done || dp_if.mem_rd_en || dp_if.mem_wr_en) bad++;
    end
    chk("t5_aborted", 64'(bad), 64'd0);
    dp_if.reci_exp_sum_finish = 1'b1;
    base_addr = 10'h3FF; row_len = 10'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_c1_state", 64'(dp_if.sm_state), 64'd5);
    chk("t5_c1_rd", 64'({dp_if.mem_rd_en, dp_if.mem_rd_addr}), 64'({1'b1, 10'h3FF}));
    wr_a = 0; wr_b = 0; done_c = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (dp_if.mem_wr_en && dp_if.sm_state == 3'b001) wr_a++;
      if (dp_if.mem_wr_en && dp_if.sm_state == 3'b100) wr_b++;
      if (done) done_c = c;
    end
    dp_if.reci_exp_sum_finish = 1'b0;
    chk("t5_writes_a", 64'(wr_a), 64'd2);
    chk("t5_writes_b", 64'(wr_b), 64'd2);
    chk("t5_done_cycle", 64'(done_c), 64'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_sm_ctrl.md
SPU_SM_CTRL -- requirements
Module: spu_sm_ctrl

Interface
REQ-001 Parameter AW, default 10: row-buffer address width, in 32-bit words.
REQ-002 Parameter RD_LAT, default 1: SRAM read latency, in cycles.
REQ-003 Parameter EUA_LAT, default 1: latency from read data to the exp output of the softmax datapath in EU_STAGE_A.
REQ-004 Parameter EUB_LAT, default 2: latency from read data to the normalized output of the softmax datapath in EU_STAGE_B.
REQ-005 Clock and reset SHALL be core_clk (input, 1 bit) and rst_n (input, 1 bit), with rst_n asynchronous and active-low.
REQ-006 start  in  1  request to process one token row; sampled only in IDLE.
REQ-007 base_addr  in  AW  first word address of the row; latched on start.
REQ-008 row_len  in  AW  row length in words, 4 int8 values per word; latched on start.
REQ-009 busy  out  1  high whenever sm_state != IDLE.
REQ-010 done  out  1  one-cycle pulse when the row is finished.
REQ-011 sm_state  out  3  phase code to the datapath: IDLE=000, EU_STAGE_A=001, RECI=011, EU_STAGE_B=100, MAX=101.
REQ-012 comp_rst, comp_en, adder_tree_en, reci_exp_sum_en  out  1 each  datapath strobes.
REQ-013 reci_exp_sum_finish  in  1  reciprocal-ready acknowledge from the datapath.
REQ-014 mem_rd_en / mem_rd_addr  out  1 / AW  row-buffer read port.
REQ-015 mem_wr_en / mem_wr_addr  out  1 / AW  row-buffer write port; write data is routed directly from the datapath output.
REQ-016 perf_cycles  out  24  cycles per row (see Configuration).

Function
REQ-017 The block SHALL number cycles from the edge that accepts start (cycle 0); state changes take effect on clock edges.
REQ-018 start with row_len != 0 in IDLE SHALL latch base_addr and row_len and enter MAX at cycle 1.
REQ-019 start with row_len == 0 SHALL stay in IDLE, issue no memory access, and pulse done at cycle 1.
REQ-020 start while busy SHALL be ignored.
REQ-021 Each of MAX, EU_STAGE_A and EU_STAGE_B SHALL issue one read per cycle at base_addr, base_addr+1, ... base_addr+row_len-1, starting in the first cycle of that state; addresses wrap modulo 2^AW.
REQ-022 comp_rst SHALL be high only in the first MAX cycle.
REQ-023 comp_en SHALL equal mem_rd_en delayed by RD_LAT cycles during MAX.
REQ-024 In EU_STAGE_A, adder_tree_en and mem_wr_en SHALL equal mem_rd_en delayed by RD_LAT+EUA_LAT cycles, and mem_wr_addr SHALL be the matching read address delayed by the same amount.
REQ-025 In EU_STAGE_B, mem_wr_en and mem_wr_addr SHALL be mem_rd_en and the read address delayed by RD_LAT+EUB_LAT cycles; adder_tree_en SHALL be low.
REQ-026 Each data phase SHALL advance only after its last delayed strobe: MAX->EU_STAGE_A, EU_STAGE_A->RECI, EU_STAGE_B->IDLE.
REQ-027 The delay pipeline SHALL be empty at every state transition.
REQ-028 reci_exp_sum_en SHALL pulse only in the first RECI cycle.
REQ-029 RECI SHALL hold until reci_exp_sum_finish is high, then enter EU_STAGE_B next cycle.
REQ-030 A finish that arrives in the same cycle as the en pulse SHALL be honoured.
REQ-031 done SHALL pulse in the first IDLE cycle after EU_STAGE_B.
REQ-032 Outside its phase, each strobe SHALL be 0.
REQ-033 mem_rd_en and mem_wr_en SHALL be 0 in IDLE and RECI.

Reset
REQ-034 While rst_n is low, sm_state SHALL be IDLE and every output, latched register and delay stage SHALL be 0.
REQ-035 Reset mid-row SHALL abort the row: no done pulse, no further memory access.
REQ-036 After reset release, the next start SHALL be processed normally.

Configuration
REQ-037 With SPU_SM_CTRL_PERF_EN defined, perf_cycles SHALL count the cycles from cycle 0 to the done pulse inclusive, saturate at 2^24-1, and hold its value until the next accepted start.
REQ-038 Without SPU_SM_CTRL_PERF_EN, perf_cycles SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-039 Package spu_sm_pkg SHALL hold the five state codes and the default latency constants, shared with the softmax datapath.
REQ-040 Sub-module spu_sm_vld_pipe SHALL implement a parameterized-depth valid+address shift register; it SHALL be instantiated twice, once at depth RD_LAT and once at the larger of the two write depths with a selectable tap.

Verification
REQ-041 Default parameters, row_len=4, base=0x3FE, finish returned 5 cycles after reci_exp_sum_en -> MAX 1-5, reads 0x3FE,0x3FF,0x000,0x001, comp_en 2-5; EU_STAGE_A 6-11, writes 8-11; reci_exp_sum_en at 12; EU_STAGE_B 18-24, writes 21-24; done at 25.
REQ-042 row_len=0 -> done at cycle 1; no rd_en/wr_en ever; sm_state stays 000.
REQ-043 reci_exp_sum_finish held low 100 cycles -> sm_state stays 011; no memory traffic; then finish=1 -> 100 next cycle.
REQ-044 start pulsed every cycle during a row -> only one row processed; exactly one done pulse.
REQ-045 rst_n low during EU_STAGE_A, then start with row_len=2 -> all outputs 0 during reset; clean second row with exactly 2 writes per write phase.
REQ-046 With SPU_SM_CTRL_PERF_EN and REQ-041 stimulus -> perf_cycles=26 after done; without the macro -> 0.
